// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the trap sequencer: state encodings, default causes, vectors and
// system-instruction codes.
package trap_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StEnter = 2'd1,
    StTrap  = 2'd2
  } trap_state_e;

  localparam logic [31:0] CauseIrq0Default  = 32'h8000_000B;
  localparam logic [31:0] CauseIrq1Default  = 32'h8000_0007;
  localparam logic [31:0] CauseEcallDefault = 32'd11;

  localparam logic [31:0] VecIrq0  = 32'h0000_0000;
  localparam logic [31:0] VecIrq1  = 32'h0000_0004;
  localparam logic [31:0] VecEcall = 32'h0000_0010;

  // funct12 field of the SYSTEM opcode
  localparam logic [11:0] SysInstEcall = 12'h000;
  localparam logic [11:0] SysInstMret  = 12'h302;

  // Return address for an asynchronous trap; wraps mod 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Connection between the trap sequencer and the decode/branch/CSR side of the core.
interface trap_ctrl_if;
  logic        jmp_valid_i;
  logic        stall_i;
  logic        ecall_i;
  logic        mret_i;
  logic [31:0] pc_addr_i;
  logic        csr_mie_we_i;
  logic        csr_mie_wdata_i;
  logic [1:0]  int_en_o;
  logic        mie_bit_o;
  logic [31:0] mepc_o;
  logic [31:0] mcause_o;
  logic        trap_active_o;

  modport master (
    output jmp_valid_i, stall_i, ecall_i, mret_i, pc_addr_i, csr_mie_we_i, csr_mie_wdata_i,
    input  int_en_o, mie_bit_o, mepc_o, mcause_o, trap_active_o
  );

  modport slave (
    input  jmp_valid_i, stall_i, ecall_i, mret_i, pc_addr_i, csr_mie_we_i, csr_mie_wdata_i,
    output int_en_o, mie_bit_o, mepc_o, mcause_o, trap_active_o
  );
endinterface

// File: rtl/trap_ctrl_irq_sync.sv
// Multi-flop synchroniser for one asynchronous IRQ line followed by a rising-edge detector.
module trap_ctrl_irq_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic res_n,
  input  logic irq_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/trap_ctrl.sv
// Interrupt/trap sequencer: latches IRQ edges as pending, injects a trap into a jump-free cycle,
// handles ECALL/MRET and owns mie/mpie, mepc and mcause.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] CAUSE_IRQ0  = CauseIrq0Default,
  parameter logic [31:0] CAUSE_IRQ1  = CauseIrq1Default,
  parameter logic [31:0] CAUSE_ECALL = CauseEcallDefault
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic [1:0]  irq_i,
  trap_ctrl_if.slave  bus
);

  logic [1:0]  irq_rise;
  trap_state_e state_q;
  logic        sel_q;
  logic [1:0]  pend_q;
  logic        mie_q;
  logic        mpie_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;

  for (genvar k = 0; k < 2; k++) begin : g_sync
    trap_ctrl_irq_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk   (clk),
      .res_n (res_n),
      .irq_i (irq_i[k]),
      .rise_o(irq_rise[k])
    );
  end

  logic       ecall_take;
  logic       mret_take;
  logic       enter_acc;
  logic [1:0] pend_clr;

  assign ecall_take = (state_q == StIdle) && bus.ecall_i && bus.jmp_valid_i;
  assign mret_take  = (state_q != StEnter) && bus.mret_i && bus.jmp_valid_i;
  assign enter_acc  = (state_q == StEnter) && !bus.jmp_valid_i && !bus.stall_i;
  assign pend_clr   = enter_acc ? (sel_q ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q  <= StIdle;
      sel_q    <= 1'b0;
      pend_q   <= 2'b00;
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      mepc_q   <= '0;
      mcause_q <= '0;
    end else begin
      // A new edge on the bit being cleared keeps it pending.
      pend_q <= (pend_q & ~pend_clr) | irq_rise;
      unique case (state_q)
        StIdle: begin
          if (ecall_take) begin
            mepc_q   <= bus.pc_addr_i;
            mcause_q <= CAUSE_ECALL;
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
            state_q  <= StTrap;
          end else begin
            if ((pend_q != 2'b00) && mie_q) begin
              state_q <= StEnter;
              sel_q   <= ~pend_q[0];
            end
            if (mret_take) begin
              mie_q  <= mpie_q;
              mpie_q <= 1'b1;
            end else if (bus.csr_mie_we_i) begin
              mie_q <= bus.csr_mie_wdata_i;
            end
          end
        end
        StEnter: begin
          if (enter_acc) begin
            mepc_q   <= next_pc(bus.pc_addr_i);
            mcause_q <= sel_q ? CAUSE_IRQ1 : CAUSE_IRQ0;
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
            state_q  <= StTrap;
          end
        end
        StTrap: begin
          if (mret_take) begin
            mie_q   <= mpie_q;
            mpie_q  <= 1'b1;
            state_q <= StIdle;
          end else if (bus.csr_mie_we_i) begin
            mie_q <= bus.csr_mie_wdata_i;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    bus.int_en_o = 2'b00;
    if (state_q == StEnter) begin
      bus.int_en_o = sel_q ? 2'b10 : 2'b01;
    end
  end

  assign bus.mie_bit_o     = mie_q;
  assign bus.mepc_o        = mepc_q;
  assign bus.mcause_o      = mcause_q;
  assign bus.trap_active_o = (state_q == StTrap);

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed scoreboard bench for trap_ctrl: expected trap requests and trap entries are queued by
// the stimulus and checked by independent monitors.
module tb_trap_ctrl;

  localparam logic [31:0] C_IRQ0  = 32'h8000_000B;
  localparam logic [31:0] C_IRQ1  = 32'h8000_0007;
  localparam logic [31:0] C_ECALL = 32'd11;

  typedef struct packed {
    logic [31:0] mepc;
    logic [31:0] mcause;
  } trap_exp_t;

  logic       clk;
  logic       res_n;
  logic [1:0] irq_i;

  trap_ctrl_if bus ();

  trap_ctrl dut (
    .clk  (clk),
    .res_n(res_n),
    .irq_i(irq_i),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [1:0] en_q[$];
  trap_exp_t  tr_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Polls trap_active_o at falling edges; ends aligned just after a rising edge.
  task automatic wait_trap(input logic want, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.trap_active_o == want) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: trap_active never reached %0b within 30 cycles", name, want);
    end
    tick();
  endtask

  task automatic do_mret();
    bus.jmp_valid_i = 1'b1;
    bus.mret_i      = 1'b1;
    tick();
    bus.jmp_valid_i = 1'b0;
    bus.mret_i      = 1'b0;
  endtask

  task automatic pulse_irq(input logic [1:0] lines);
    irq_i = lines;
    tick();
    tick();
    irq_i = 2'b00;
  endtask

  // Monitors: a rising trap request and a trap entry each consume one queued expectation.
  initial begin
    logic [1:0] en_prev = 2'b00;
    logic       tr_prev = 1'b0;
    trap_exp_t  t;
    forever begin
      @(negedge clk);
      if (res_n) begin
        if (bus.int_en_o != 2'b00 && en_prev == 2'b00) begin
          if (en_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL int_en_unexpected: got %b, expected no request", bus.int_en_o);
          end else begin
            check32("int_en", {30'd0, bus.int_en_o}, {30'd0, en_q.pop_front()});
          end
        end
        if (bus.trap_active_o && !tr_prev) begin
          if (tr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL trap_unexpected: mepc=%h mcause=%h", bus.mepc_o, bus.mcause_o);
          end else begin
            t = tr_q.pop_front();
            check32("trap_mepc", bus.mepc_o, t.mepc);
            check32("trap_mcause", bus.mcause_o, t.mcause);
            check32("trap_mie_clr", {31'd0, bus.mie_bit_o}, 32'd0);
          end
        end
      end
      en_prev = bus.int_en_o;
      tr_prev = bus.trap_active_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    res_n               = 1'b0;
    irq_i               = 2'b11;
    bus.jmp_valid_i     = 1'b0;
    bus.stall_i         = 1'b0;
    bus.ecall_i         = 1'b0;
    bus.mret_i          = 1'b0;
    bus.pc_addr_i       = 32'h40;
    bus.csr_mie_we_i    = 1'b0;
    bus.csr_mie_wdata_i = 1'b0;

    // Reset with both IRQs held high
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("rst_int_en", {30'd0, bus.int_en_o}, 32'd0);
    check32("rst_mie", {31'd0, bus.mie_bit_o}, 32'd0);
    check32("rst_mepc", bus.mepc_o, 32'd0);
    check32("rst_mcause", bus.mcause_o, 32'd0);
    check32("rst_trap_active", {31'd0, bus.trap_active_o}, 32'd0);
    tick();
    res_n = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    check32("mie0_no_int_en", {30'd0, bus.int_en_o}, 32'd0);
    tick();

    // Both pending: enabling mie takes irq0, then irq1 after MRET
    en_q.push_back(2'b01);
    tr_q.push_back({32'h44, C_IRQ0});
    en_q.push_back(2'b10);
    tr_q.push_back({32'h84, C_IRQ1});
    bus.csr_mie_we_i    = 1'b1;
    bus.csr_mie_wdata_i = 1'b1;
    tick();
    bus.csr_mie_we_i = 1'b0;
    wait_trap(1'b1, "t1_trap0");
    irq_i         = 2'b00;
    bus.pc_addr_i = 32'h80;
    do_mret();
    wait_trap(1'b1, "t1_trap1");
    do_mret();
    @(negedge clk);
    check32("t1_mret_mie", {31'd0, bus.mie_bit_o}, 32'd1);
    check32("t1_mret_idle", {31'd0, bus.trap_active_o}, 32'd0);
    tick();

    // Single irq1 pulse
    bus.pc_addr_i = 32'h100;
    en_q.push_back(2'b10);
    tr_q.push_back({32'h104, C_IRQ1});
    pulse_irq(2'b10);
    wait_trap(1'b1, "t2_trap");
    do_mret();
    @(negedge clk);
    check32("t2_mret_mie", {31'd0, bus.mie_bit_o}, 32'd1);
    check32("t2_mret_idle", {31'd0, bus.trap_active_o}, 32'd0);
    tick();

    // Trap request held off by resolving jumps
    bus.pc_addr_i   = 32'h300;
    bus.jmp_valid_i = 1'b1;
    en_q.push_back(2'b01);
    tr_q.push_back({32'h304, C_IRQ0});
    pulse_irq(2'b01);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (bus.int_en_o != 2'b00) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) begin
        checks++;
        errors++;
        $display("FAIL t3_enter: int_en stayed 00 for 30 cycles");
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check32("t3_hold_int_en", {30'd0, bus.int_en_o}, 32'd1);
      check32("t3_hold_no_trap", {31'd0, bus.trap_active_o}, 32'd0);
    end
    tick();
    bus.jmp_valid_i = 1'b0;
    wait_trap(1'b1, "t3_trap");
    do_mret();

    // ECALL in the cycle the pending irq0 would otherwise enter
    irq_i = 2'b01;
    repeat (3) tick();
    tr_q.push_back({32'h200, C_ECALL});
    bus.pc_addr_i   = 32'h200;
    bus.jmp_valid_i = 1'b1;
    bus.ecall_i     = 1'b1;
    tick();
    bus.jmp_valid_i = 1'b0;
    bus.ecall_i     = 1'b0;
    wait_trap(1'b1, "t4_ecall");
    irq_i         = 2'b00;
    bus.pc_addr_i = 32'h500;
    en_q.push_back(2'b01);
    tr_q.push_back({32'h504, C_IRQ0});
    do_mret();
    wait_trap(1'b1, "t4_irq0");
    do_mret();
    @(negedge clk);
    check32("t4_mret_mie", {31'd0, bus.mie_bit_o}, 32'd1);
    tick();

    // Simultaneous edges: irq0 first, irq1 after MRET without a new edge
    bus.pc_addr_i = 32'h600;
    en_q.push_back(2'b01);
    tr_q.push_back({32'h604, C_IRQ0});
    en_q.push_back(2'b10);
    tr_q.push_back({32'h704, C_IRQ1});
    pulse_irq(2'b11);
    wait_trap(1'b1, "t5_irq0");
    bus.pc_addr_i = 32'h700;
    do_mret();
    wait_trap(1'b1, "t5_irq1");

    // Asynchronous reset while in TRAP
    res_n = 1'b0;
    #2;
    check32("t6_rst_trap_active", {31'd0, bus.trap_active_o}, 32'd0);
    check32("t6_rst_mie", {31'd0, bus.mie_bit_o}, 32'd0);
    check32("t6_rst_int_en", {30'd0, bus.int_en_o}, 32'd0);
    check32("t6_rst_mepc", bus.mepc_o, 32'd0);
    check32("t6_rst_mcause", bus.mcause_o, 32'd0);
    tick();
    res_n = 1'b1;
    bus.csr_mie_we_i    = 1'b1;
    bus.csr_mie_wdata_i = 1'b1;
    tick();
    bus.csr_mie_we_i = 1'b0;
    repeat (5) @(negedge clk);
    check32("t6_pend_cleared", {30'd0, bus.int_en_o}, 32'd0);
    check32("t6_csr_mie", {31'd0, bus.mie_bit_o}, 32'd1);
    tick();

    // mepc wraps past the top of the address space
    bus.pc_addr_i = 32'hFFFF_FFFC;
    en_q.push_back(2'b10);
    tr_q.push_back({32'h0, C_IRQ1});
    pulse_irq(2'b10);
    wait_trap(1'b1, "t6_wrap");
    do_mret();
    repeat (4) tick();

    check32("drain_en_q", en_q.size(), 32'd0);
    check32("drain_tr_q", tr_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
